semaforo_conflict_monitor: RTL and testbench

- Downstream safety stage for the two-way traffic-light controller. Consumes the controller's six lamp outputs and drives the physical lamp bus.
- Passes legal lamp patterns through with 1-cycle registered latency.
- Blocks illegal combinations (forces both directions to red) and detects stuck patterns.
- On a confirmed fault, latches it and drives night-style flashing yellow until software clears it.

---
 rtl/semaforo_pkg.sv | 40 ++++
 rtl/semaforo_conflict_monitor_if.sv | 35 +++
 rtl/semaforo_flasher.sv | 52 +++++
 rtl/semaforo_conflict_monitor.sv | 176 +++++++++++++++++
 tb/tb_semaforo_conflict_monitor.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Shared lamp patterns, fault codes, monitor states and the
//               lamp-pattern legality check for the traffic-light monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

  // Lamp bit order: {redA, yellowA, greenA, redB, yellowB, greenB}
  localparam logic [5:0] GREEN_RED  = 6'b001100;
  localparam logic [5:0] YELLOW_RED = 6'b010100;
  localparam logic [5:0] RED_GREEN  = 6'b100001;
  localparam logic [5:0] RED_YELLOW = 6'b100010;
  localparam logic [5:0] ALL_OFF    = 6'b000000;
  localparam logic [5:0] YELLOW_ON  = 6'b010010;
  localparam logic [5:0] ALL_RED    = 6'b100100;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_STUCK   = 2'b10
  } fault_code_t;

  typedef enum logic [1:0] {
    MONITOR = 2'b00,
    PENDING = 2'b01,
    FAULT   = 2'b10
  } monitor_state_t;

  // ALL_RED is only ever produced by this stage; the controller never emits it.
  function automatic logic is_legal(input logic [5:0] pattern);
    case (pattern)
      GREEN_RED, YELLOW_RED, RED_GREEN, RED_YELLOW, ALL_OFF, YELLOW_ON: return 1'b1;
      default:                                                          return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/semaforo_conflict_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_conflict_monitor_if
// Description : Lamp bus between the light controller, the conflict monitor
//               and the software fault-clear path.
// Revision    : 1.0 - initial release
// ============================================================================
interface semaforo_conflict_monitor_if;

  logic [5:0] lamps_in;
  logic       clr_fault;
  logic [5:0] lamps_out;
  logic       fault;
  logic [1:0] fault_code;

  // Controller / software side
  modport master (
    output lamps_in,
    output clr_fault,
    input  lamps_out,
    input  fault,
    input  fault_code
  );

  // Monitor side
  modport slave (
    input  lamps_in,
    input  clr_fault,
    output lamps_out,
    output fault,
    output fault_code
  );

endinterface
`default_nettype wire

// File: rtl/semaforo_flasher.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_flasher
// Description : Fault flasher. Alternates YELLOW_ON / ALL_OFF with each phase
//               lasting FLASH_HALF cycles. Exposes the pattern the lamp
//               register must load at the coming edge so the lamp drive
//               stays a single register.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_flasher
  import semaforo_pkg::*;
#(
  parameter int FLASH_HALF = 1
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       enable,
  input  wire logic       restart,
  output logic [5:0]      pattern_next
);

  localparam int CNT_W = $clog2(FLASH_HALF + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FLASH_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;   // 0: yellow phase, 1: dark phase
  logic             w_wrap;

  assign w_wrap       = (r_cnt == c_LAST);
  // Phase that will be current after this edge while the flasher runs
  assign pattern_next = (r_phase ^ w_wrap) ? ALL_OFF : YELLOW_ON;

  // Phase timer: restart parks on the first yellow cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (enable) begin
      if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/semaforo_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_conflict_monitor
// Description : Safety stage between the traffic-light controller and the
//               lamp drivers. Passes legal patterns with one cycle of
//               latency, forces all-red on illegal patterns, and latches
//               confirmed conflict or stuck faults into a flashing-yellow
//               mode until software clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_conflict_monitor
  import semaforo_pkg::*;
#(
  parameter int CONFLICT_CYCLES = 2,
  parameter int MAX_DWELL       = 6,
  parameter int FLASH_HALF      = 1
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  semaforo_conflict_monitor_if.slave bus
);

  // Counter ranges: conf reaches CONFLICT_CYCLES, dwell reaches MAX_DWELL+1
  localparam int CONF_W = $clog2(CONFLICT_CYCLES + 1);
  localparam int DWELL_W = $clog2(MAX_DWELL + 2);
  localparam logic [CONF_W-1:0]  c_CONF_MAX  = CONF_W'(CONFLICT_CYCLES);
  localparam logic [DWELL_W-1:0] c_DWELL_MAX = DWELL_W'(MAX_DWELL + 1);

  monitor_state_t     r_state, w_state_next;
  logic [CONF_W-1:0]  r_conf_cnt, w_conf_next, w_conf_inc;
  logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_next, w_dwell_inc, w_dwell_new;
  logic [5:0]         r_prev;
  logic [5:0]         r_lamps, w_lamps_next;
  logic               r_fault, w_fault_next;
  fault_code_t        r_code, w_code_next, w_cause;
  logic               w_enter_fault;
  logic               w_legal, w_same, w_stuck, w_conf_hit, w_clear;
  logic [5:0]         w_flash_next;

  assign w_legal     = is_legal(bus.lamps_in);
  assign w_same      = (bus.lamps_in == r_prev) && (bus.lamps_in != ALL_OFF);
  assign w_dwell_inc = (r_dwell_cnt == c_DWELL_MAX) ? r_dwell_cnt : r_dwell_cnt + DWELL_W'(1);
  assign w_dwell_new = w_same ? w_dwell_inc : DWELL_W'(1);
  assign w_stuck     = (w_dwell_new == c_DWELL_MAX);
  assign w_conf_inc  = (r_conf_cnt == c_CONF_MAX) ? r_conf_cnt : r_conf_cnt + CONF_W'(1);
  assign w_conf_hit  = (w_conf_inc == c_CONF_MAX);
  assign w_clear     = bus.clr_fault && w_legal;

  semaforo_flasher #(
    .FLASH_HALF (FLASH_HALF)
  ) u_flasher (
    .clock        (clock),
    .reset        (reset),
    .enable       (r_state == FAULT),
    .restart      (w_enter_fault),
    .pattern_next (w_flash_next)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= MONITOR;
    else        r_state <= w_state_next;
  end

  // Next-state decision; an illegal sample always outranks the dwell check
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MONITOR: begin
        if (!w_legal)     w_state_next = (CONFLICT_CYCLES == 1) ? FAULT : PENDING;
        else if (w_stuck) w_state_next = FAULT;
        else              w_state_next = MONITOR;
      end
      PENDING: begin
        if (!w_legal) w_state_next = w_conf_hit ? FAULT : PENDING;
        else          w_state_next = MONITOR;
      end
      FAULT: begin
        if (w_clear) w_state_next = MONITOR;
        else         w_state_next = FAULT;
      end
      default: w_state_next = MONITOR;
    endcase
  end

  // Output and counter next values for the coming edge
  always_comb begin
    w_lamps_next  = r_lamps;
    w_fault_next  = r_fault;
    w_code_next   = r_code;
    w_conf_next   = r_conf_cnt;
    w_dwell_next  = r_dwell_cnt;
    w_enter_fault = 1'b0;
    w_cause       = FC_NONE;
    case (r_state)
      MONITOR: begin
        if (!w_legal) begin
          if (CONFLICT_CYCLES == 1) begin
            w_enter_fault = 1'b1;
            w_cause       = FC_ILLEGAL;
          end else begin
            w_lamps_next = ALL_RED;
            w_conf_next  = CONF_W'(1);
          end
        end else if (w_stuck) begin
          w_enter_fault = 1'b1;
          w_cause       = FC_STUCK;
          w_dwell_next  = w_dwell_new;
        end else begin
          w_lamps_next = bus.lamps_in;
          w_dwell_next = w_dwell_new;
        end
      end
      PENDING: begin
        if (!w_legal) begin
          w_conf_next = w_conf_inc;
          if (w_conf_hit) begin
            w_enter_fault = 1'b1;
            w_cause       = FC_ILLEGAL;
          end else begin
            w_lamps_next = ALL_RED;
          end
        end else begin
          w_lamps_next = bus.lamps_in;
          w_conf_next  = '0;
          w_dwell_next = DWELL_W'(1);
        end
      end
      FAULT: begin
        if (w_clear) begin
          w_fault_next = 1'b0;
          w_code_next  = FC_NONE;
          w_lamps_next = bus.lamps_in;
          w_conf_next  = '0;
          w_dwell_next = DWELL_W'(1);
        end else begin
          w_lamps_next = w_flash_next;
        end
      end
      default: begin
        w_lamps_next = ALL_RED;
      end
    endcase
    // Fault entry starts the flash on yellow and records the first cause
    if (w_enter_fault) begin
      w_fault_next = 1'b1;
      w_code_next  = w_cause;
      w_lamps_next = YELLOW_ON;
    end
  end

  // Registered outputs, counters and previous-sample history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lamps     <= ALL_RED;
      r_fault     <= 1'b0;
      r_code      <= FC_NONE;
      r_conf_cnt  <= '0;
      r_dwell_cnt <= '0;
      r_prev      <= ALL_OFF;
    end else begin
      r_lamps     <= w_lamps_next;
      r_fault     <= w_fault_next;
      r_code      <= w_code_next;
      r_conf_cnt  <= w_conf_next;
      r_dwell_cnt <= w_dwell_next;
      r_prev      <= bus.lamps_in;
    end
  end

  assign bus.lamps_out  = r_lamps;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_conflict_monitor
// Description : Directed plus randomized bench for the conflict monitor,
//               checked against a behavioural lamp-safety model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_conflict_monitor;

  localparam int CC = 2;
  localparam int MD = 6;
  localparam int FH = 1;

  localparam logic [5:0] P_GR  = 6'b001100;
  localparam logic [5:0] P_YR  = 6'b010100;
  localparam logic [5:0] P_RG  = 6'b100001;
  localparam logic [5:0] P_RY  = 6'b100010;
  localparam logic [5:0] P_OFF = 6'b000000;
  localparam logic [5:0] P_YEL = 6'b010010;
  localparam logic [5:0] P_RED = 6'b100100;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  semaforo_conflict_monitor_if bus();

  semaforo_conflict_monitor #(
    .CONFLICT_CYCLES (CC),
    .MAX_DWELL       (MD),
    .FLASH_HALF      (FH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: run lengths and fault age in plain integers
  logic [5:0] legal_tab [6];
  logic [5:0] m_out, m_prev;
  logic       m_fault;
  logic [1:0] m_code;
  int         m_run, m_ill, m_age;

  function automatic logic m_legal(input logic [5:0] p);
    for (int k = 0; k < 6; k++) if (legal_tab[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_out = P_RED; m_prev = P_OFF; m_fault = 1'b0; m_code = 2'd0;
    m_run = 0; m_ill = 0; m_age = 0;
  endtask

  task automatic model_enter(input logic [1:0] code);
    m_fault = 1'b1; m_code = code; m_age = 0; m_ill = 0; m_out = P_YEL;
  endtask

  task automatic model_edge(input logic [5:0] x, input logic clr);
    if (m_fault) begin
      if (clr && m_legal(x)) begin
        m_fault = 1'b0; m_code = 2'd0; m_out = x; m_run = 1; m_ill = 0;
      end else begin
        m_age++;
        m_out = (((m_age / FH) % 2) == 1) ? P_OFF : P_YEL;
      end
    end else if (!m_legal(x)) begin
      m_ill++;
      if (m_ill >= CC) model_enter(2'd1);
      else             m_out = P_RED;
    end else if (m_ill > 0) begin
      m_ill = 0; m_run = 1; m_out = x;
    end else begin
      m_run = (x == m_prev && x != P_OFF) ? m_run + 1 : 1;
      if (m_run > MD) model_enter(2'd2);
      else            m_out = x;
    end
    m_prev = x;
  endtask

  task automatic check(input string tag);
    n_tests++;
    assert (bus.lamps_out === m_out) else begin
      n_fail++;
      $error("FAIL %s lamps_out observed=%b expected=%b", tag, bus.lamps_out, m_out);
    end
    n_tests++;
    assert (bus.fault === m_fault) else begin
      n_fail++;
      $error("FAIL %s fault observed=%b expected=%b", tag, bus.fault, m_fault);
    end
    n_tests++;
    assert (bus.fault_code === m_code) else begin
      n_fail++;
      $error("FAIL %s fault_code observed=%b expected=%b", tag, bus.fault_code, m_code);
    end
  endtask

  task automatic step(input logic [5:0] x, input logic clr, input string tag);
    bus.lamps_in  = x;
    bus.clr_fault = clr;
    @(posedge clock);
    model_edge(x, clr);
    #1;
    check(tag);
  endtask

  logic [5:0] x_last;
  logic [5:0] x_new;

  initial begin
    legal_tab[0] = P_GR; legal_tab[1] = P_YR; legal_tab[2] = P_RG;
    legal_tab[3] = P_RY; legal_tab[4] = P_OFF; legal_tab[5] = P_YEL;
    n_tests = 0;
    n_fail  = 0;
    bus.lamps_in  = P_OFF;
    bus.clr_fault = 1'b0;
    reset = 1'b0;
    model_reset();
    #12;
    check("reset");
    reset = 1'b1;

    // Day cycle repeated three times
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) step(P_GR, 1'b0, "day");
      step(P_YR, 1'b0, "day");
      for (int k = 0; k < 3; k++) step(P_RG, 1'b0, "day");
      step(P_RY, 1'b0, "day");
    end

    // Night alternation then dark hold
    for (int k = 0; k < 20; k++) step((k % 2 == 0) ? P_OFF : P_YEL, 1'b0, "night");
    for (int k = 0; k < 30; k++) step(P_OFF, 1'b0, "dark");

    // Single illegal glitch, then a confirmed conflict
    step(P_GR, 1'b0, "glitch_pre");
    step(6'b001001, 1'b0, "glitch");
    step(P_YR, 1'b0, "glitch_post");
    step(6'b001001, 1'b0, "conflict1");
    step(6'b001001, 1'b0, "conflict2");
    for (int k = 0; k < 4; k++) step(P_RG, 1'b0, "flash");
    step(6'b111111, 1'b1, "clr_illegal");
    step(P_RG, 1'b1, "clr_legal");
    step(P_RY, 1'b0, "after_clr");

    // Stuck green for seven edges
    for (int k = 0; k < 7; k++) step(P_GR, 1'b0, "stuck");
    step(P_GR, 1'b0, "stuck_flash");
    step(P_RG, 1'b1, "stuck_clr");

    // Randomized traffic with holds, glitches and clears
    x_last = P_GR;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 35)      x_new = x_last;
      else if (r < 85) x_new = legal_tab[$urandom_range(0, 5)];
      else             x_new = 6'($urandom_range(0, 63));
      step(x_new, ($urandom_range(0, 7) == 0), "rand");
      x_last = x_new;
    end

    // Asynchronous reset in the middle of flashing
    step(P_RY, 1'b1, "pre_async");
    step(6'b110000, 1'b0, "async_c1");
    step(6'b110000, 1'b0, "async_c2");
    step(P_GR, 1'b0, "async_flash");
    step(P_GR, 1'b0, "async_flash");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    #2;
    reset = 1'b1;
    step(P_RG, 1'b0, "post_rst");
    step(P_RY, 1'b0, "post_rst");
    step(P_GR, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
